h264_mb_sched: RTL

- Frame-level macroblock scheduler for the H.264 encoder front end.
- Walks macroblock coordinates in raster order over a programmed frame size.
- Sequences the `fetch` block (start pulse, MB coordinates, wait for `fetch_finish`) and hands each fetched MB to the downstream encode stage with a start/done handshake.
- Fetch of MB n+1 overlaps encode of MB n; at most one MB is fetched-but-not-handed-off at any time.

---
 rtl/h264_mb_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/h264_mb_sched.sv
// Frame-level macroblock scheduler: raster walk, fetch sequencing and encode handoff.
// Optional fetch watchdog enabled by defining H264_MB_SCHED_TIMEOUT_EN.
module h264_mb_sched #(
    parameter int unsigned MB_CW       = 6,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start_i,
    input  logic [MB_CW-1:0] frame_mb_w_i,
    input  logic [MB_CW-1:0] frame_mb_h_i,
    output logic             fetch_start_o,
    output logic [MB_CW-1:0] fetch_mb_x_o,
    output logic [MB_CW-1:0] fetch_mb_y_o,
    input  logic             fetch_finish_i,
    output logic             enc_start_o,
    output logic [MB_CW-1:0] enc_mb_x_o,
    output logic [MB_CW-1:0] enc_mb_y_o,
    input  logic             enc_done_i,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_ISSUE = 2'd1,
        F_WAIT  = 2'd2,
        F_HOLD  = 2'd3
    } f_state_t;

    typedef enum logic {
        E_IDLE = 1'b0,
        E_RUN  = 1'b1
    } e_state_t;

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("h264_mb_sched: TIMEOUT_CYC must be nonzero");
    end

    f_state_t         f_state;
    f_state_t         f_next;
    e_state_t         e_state;
    e_state_t         e_next;
    logic [MB_CW-1:0] mb_w;
    logic [MB_CW-1:0] mb_h;

    logic accept;
    logic enc_ready;
    logic handoff;
    logic last_mb;
    logic frame_end;
    logic timeout;

`ifdef H264_MB_SCHED_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`endif

    // Next-state logic for both FSMs; a handoff moves the fetched MB into the encoder.
    always_comb begin
        f_next    = f_state;
        e_next    = e_state;
        handoff   = 1'b0;
        timeout   = 1'b0;
        accept    = frame_start_i && !busy_o && (frame_mb_w_i != '0) && (frame_mb_h_i != '0);
        enc_ready = (e_state == E_IDLE) || enc_done_i;
        last_mb   = (fetch_mb_x_o == mb_w - MB_CW'(1)) && (fetch_mb_y_o == mb_h - MB_CW'(1));
        frame_end = busy_o && (e_state == E_RUN) && enc_done_i && (f_state == F_IDLE);
`ifdef H264_MB_SCHED_TIMEOUT_EN
        timeout   = (f_state == F_WAIT) && !fetch_finish_i
                    && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

        case (f_state)
            F_IDLE: begin
                if (accept) begin
                    f_next = F_ISSUE;
                end
            end
            F_ISSUE: begin
                f_next = F_WAIT;
            end
            F_WAIT: begin
                // Bypass F_HOLD when the encoder is already free.
                if (fetch_finish_i) begin
                    if (e_state == E_IDLE) begin
                        handoff = 1'b1;
                    end else begin
                        f_next = F_HOLD;
                    end
                end
            end
            F_HOLD: begin
                if (enc_ready) begin
                    handoff = 1'b1;
                end
            end
            default: begin
                f_next = F_IDLE;
            end
        endcase

        if (handoff) begin
            f_next = last_mb ? F_IDLE : F_ISSUE;
        end

        case (e_state)
            E_IDLE: begin
                if (handoff) begin
                    e_next = E_RUN;
                end
            end
            E_RUN: begin
                if (enc_done_i && !handoff) begin
                    e_next = E_IDLE;
                end
            end
            default: begin
                e_next = E_IDLE;
            end
        endcase

        if (timeout) begin
            f_next = F_IDLE;
            e_next = E_IDLE;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f_state <= F_IDLE;
            e_state <= E_IDLE;
        end else begin
            f_state <= f_next;
            e_state <= e_next;
        end
    end

    // Registered outputs, frame size and raster coordinates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_start_o <= 1'b0;
            enc_start_o   <= 1'b0;
            frame_done_o  <= 1'b0;
            busy_o        <= 1'b0;
            mb_w          <= '0;
            mb_h          <= '0;
            fetch_mb_x_o  <= '0;
            fetch_mb_y_o  <= '0;
            enc_mb_x_o    <= '0;
            enc_mb_y_o    <= '0;
        end else begin
            fetch_start_o <= (f_next == F_ISSUE);
            enc_start_o   <= handoff;
            frame_done_o  <= frame_end;

            if (accept) begin
                busy_o <= 1'b1;
            end else if (frame_end || timeout) begin
                busy_o <= 1'b0;
            end

            if (accept) begin
                mb_w         <= frame_mb_w_i;
                mb_h         <= frame_mb_h_i;
                fetch_mb_x_o <= '0;
                fetch_mb_y_o <= '0;
            end else if (handoff) begin
                enc_mb_x_o <= fetch_mb_x_o;
                enc_mb_y_o <= fetch_mb_y_o;
                // The last MB leaves the coordinates in place so they never pass w-1/h-1.
                if (!last_mb) begin
                    if (fetch_mb_x_o == mb_w - MB_CW'(1)) begin
                        fetch_mb_x_o <= '0;
                        fetch_mb_y_o <= fetch_mb_y_o + MB_CW'(1);
                    end else begin
                        fetch_mb_x_o <= fetch_mb_x_o + MB_CW'(1);
                    end
                end
            end
        end
    end

`ifdef H264_MB_SCHED_TIMEOUT_EN
    // Fetch watchdog: counts cycles spent in F_WAIT; err_o is sticky until the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            if ((f_state == F_WAIT) && (f_next == F_WAIT)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (accept) begin
                err_o <= 1'b0;
            end else if (timeout) begin
                err_o <= 1'b1;
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
